// File: rtl/lcm_tx_arbiter.sv
// lcm_tx_arbiter: frame-granular round-robin merge of four frame sources
// (ARP, PTP, NMAC, TSMP) onto the 134-bit LCM transmit datapath.
// Optional watchdog abort: define LCM_ARB_TIMEOUT_EN to compile it in.
module lcm_tx_arbiter #(
  parameter int unsigned TIMEOUT_CYC = 1023
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic [3:0]   iv_req,
  output logic [3:0]   ov_grant,
  input  logic [133:0] iv_data0,
  input  logic [133:0] iv_data1,
  input  logic [133:0] iv_data2,
  input  logic [133:0] iv_data3,
  input  logic         i_data0_wr,
  input  logic         i_data1_wr,
  input  logic         i_data2_wr,
  input  logic         i_data3_wr,
  input  logic         i_tx_rdy,
  output logic [133:0] ov_data,
  output logic         o_data_wr,
  output logic [15:0]  ov_err_cnt,
  output logic [15:0]  ov_timeout_cnt
);

  localparam int unsigned NSRC = 4;
  localparam int unsigned DW   = 134;
  localparam int unsigned CW   = 16;

  localparam logic [1:0] HEAD = 2'b01;
  localparam logic [1:0] BODY = 2'b11;
  localparam logic [1:0] TAIL = 2'b10;

  localparam logic [CW-1:0] TIMEOUT_LIM = CW'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    IDLE_S      = 2'd0,
    WAIT_HEAD_S = 2'd1,
    TRANS_S     = 2'd2,
    GAP_S       = 2'd3
  } state_t;

  state_t          state;
  logic [1:0]      rr_ptr;
  logic [1:0]      gidx;
  logic [DW-1:0]   din [NSRC];
  logic [NSRC-1:0] wr_vec;
  logic [DW-1:0]   sel_data;
  logic [1:0]      sel_type;
  logic            sel_wr;
  logic [1:0]      pick;
  logic            pick_vld;
  logic            waiting;
  logic            wdog_en;
  logic [CW-1:0]   idle_cnt;
  logic            timeout_hit;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == '1) ? v : v + CW'(1);
  endfunction

  assign din[0] = iv_data0;
  assign din[1] = iv_data1;
  assign din[2] = iv_data2;
  assign din[3] = iv_data3;
  assign wr_vec = {i_data3_wr, i_data2_wr, i_data1_wr, i_data0_wr};

  // Only the granted source is observed; everything else is ignored.
  assign waiting  = (state == WAIT_HEAD_S) || (state == TRANS_S);
  assign sel_data = din[gidx];
  assign sel_type = sel_data[DW-1:DW-2];
  assign sel_wr   = waiting && wr_vec[gidx];

  // Round-robin pick: first requesting source at or above rr_ptr, wrapping.
  always_comb begin
    logic [1:0] idx;
    pick     = rr_ptr;
    pick_vld = 1'b0;
    idx      = '0;
    for (int i = 0; i < NSRC; i++) begin
      idx = rr_ptr + 2'(i);
      if (!pick_vld && iv_req[idx]) begin
        pick     = idx;
        pick_vld = 1'b1;
      end
    end
  end

`ifdef LCM_ARB_TIMEOUT_EN
  assign wdog_en = 1'b1;

  // Idle-cycle counter: runs while a grant waits for data, cleared by every granted beat.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      idle_cnt <= '0;
    end else if (!waiting || sel_wr || timeout_hit) begin
      idle_cnt <= '0;
    end else begin
      idle_cnt <= sat_inc(idle_cnt);
    end
  end
`else
  assign wdog_en  = 1'b0;
  assign idle_cnt = '0;
`endif

  // Fires on the sampling edge that completes the TIMEOUT_CYC-th idle cycle.
  assign timeout_hit = wdog_en && waiting && !sel_wr && (idle_cnt == TIMEOUT_LIM);

  // Arbitration FSM with registered grant, data, valid and counters.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state          <= IDLE_S;
      rr_ptr         <= '0;
      gidx           <= '0;
      ov_grant       <= '0;
      ov_data        <= '0;
      o_data_wr      <= 1'b0;
      ov_err_cnt     <= '0;
      ov_timeout_cnt <= '0;
    end else begin
      o_data_wr <= 1'b0;
      case (state)
        IDLE_S: begin
          if (i_tx_rdy && pick_vld) begin
            ov_grant <= 4'b0001 << pick;
            gidx     <= pick;
            state    <= WAIT_HEAD_S;
          end
        end

        WAIT_HEAD_S: begin
          if (sel_wr) begin
            if (sel_type == HEAD) begin
              ov_data   <= sel_data;
              o_data_wr <= 1'b1;
              state     <= TRANS_S;
            end else begin
              ov_err_cnt <= sat_inc(ov_err_cnt);
            end
          end else if (timeout_hit) begin
            ov_grant       <= '0;
            rr_ptr         <= gidx + 2'd1;
            ov_timeout_cnt <= sat_inc(ov_timeout_cnt);
            state          <= GAP_S;
          end
        end

        TRANS_S: begin
          if (sel_wr) begin
            case (sel_type)
              BODY: begin
                ov_data   <= sel_data;
                o_data_wr <= 1'b1;
              end
              TAIL: begin
                ov_data   <= sel_data;
                o_data_wr <= 1'b1;
                ov_grant  <= '0;
                rr_ptr    <= gidx + 2'd1;
                state     <= GAP_S;
              end
              HEAD: begin
                // A new head mid-frame truncates the current frame with a forced tail.
                ov_data    <= {TAIL, sel_data[DW-3:0]};
                o_data_wr  <= 1'b1;
                ov_err_cnt <= sat_inc(ov_err_cnt);
                ov_grant   <= '0;
                rr_ptr     <= gidx + 2'd1;
                state      <= GAP_S;
              end
              default: begin
                ov_err_cnt <= sat_inc(ov_err_cnt);
              end
            endcase
          end else if (timeout_hit) begin
            ov_data        <= {TAIL, (DW-2)'(0)};
            o_data_wr      <= 1'b1;
            ov_grant       <= '0;
            rr_ptr         <= gidx + 2'd1;
            ov_timeout_cnt <= sat_inc(ov_timeout_cnt);
            state          <= GAP_S;
          end
        end

        GAP_S: begin
          state <= IDLE_S;
        end

        default: begin
          state <= IDLE_S;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lcm_tx_arbiter.sv
// Directed bench for lcm_tx_arbiter with a queue-based scoreboard for output
// beats and grant order; define LCM_ARB_TIMEOUT_EN to also exercise the watchdog.
module tb_lcm_tx_arbiter;

  logic         clk;
  logic         rst_n;
  logic [3:0]   req;
  logic [3:0]   ov_grant;
  logic [133:0] data [4];
  logic [3:0]   wr;
  logic         tx_rdy;
  logic [133:0] ov_data;
  logic         o_data_wr;
  logic [15:0]  ov_err_cnt;
  logic [15:0]  ov_timeout_cnt;

  int checks = 0;
  int errors = 0;

  logic [133:0] exp_q [$];
  logic [3:0]   gq [$];
  logic [3:0]   prev_grant;

  lcm_tx_arbiter #(.TIMEOUT_CYC(8)) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .iv_req         (req),
    .ov_grant       (ov_grant),
    .iv_data0       (data[0]),
    .iv_data1       (data[1]),
    .iv_data2       (data[2]),
    .iv_data3       (data[3]),
    .i_data0_wr     (wr[0]),
    .i_data1_wr     (wr[1]),
    .i_data2_wr     (wr[2]),
    .i_data3_wr     (wr[3]),
    .i_tx_rdy       (tx_rdy),
    .ov_data        (ov_data),
    .o_data_wr      (o_data_wr),
    .ov_err_cnt     (ov_err_cnt),
    .ov_timeout_cnt (ov_timeout_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [133:0] act, input logic [133:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  function automatic logic [131:0] pl(input int s, input int k);
    logic [131:0] marker;
    marker = 132'h5A;
    return (marker << 124) | (132'(s) << 64) | 132'(k);
  endfunction

  // One beat on source s; the forwarded value (with expected type bits) is queued.
  task automatic drive(input int s, input logic [1:0] t, input logic [131:0] p,
                       input bit fwd, input logic [1:0] exp_t);
    data[s] = {t, p};
    wr[s]   = 1'b1;
    if (fwd) exp_q.push_back({exp_t, p});
    @(negedge clk);
    wr[s] = 1'b0;
  endtask

  task automatic send(input int s, input logic [1:0] t, input int k);
    drive(s, t, pl(s, k), 1'b1, t);
  endtask

  task automatic wait_grant(input int s);
    int n;
    logic [3:0] want;
    n    = 0;
    want = 4'b0001 << s;
    while (ov_grant !== want && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("grant_wait", 134'(ov_grant), 134'(want));
  endtask

  // Data monitor: every output beat must match the head of the expected queue.
  always @(negedge clk) begin
    if (rst_n && o_data_wr === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_beat @%0t: got %h expected none", $time, ov_data);
      end else begin
        chk("out_beat", ov_data, exp_q.pop_front());
      end
    end
  end

  // Grant monitor: each new grant must follow the expected round-robin order.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_grant <= '0;
    end else begin
      if (ov_grant !== 4'b0000 && prev_grant === 4'b0000) begin
        if (gq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_grant @%0t: got %b expected none", $time, ov_grant);
        end else begin
          chk("grant_order", 134'(ov_grant), 134'(gq.pop_front()));
        end
      end
      prev_grant <= ov_grant;
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    rst_n  = 1'b0;
    req    = '0;
    wr     = '0;
    tx_rdy = 1'b0;
    for (int i = 0; i < 4; i++) data[i] = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset state
    chk("rst_grant", 134'(ov_grant), 134'(0));
    chk("rst_wr", 134'(o_data_wr), 134'(0));
    chk("rst_data", ov_data, 134'(0));
    chk("rst_err", 134'(ov_err_cnt), 134'(0));
    chk("rst_tmo", 134'(ov_timeout_cnt), 134'(0));

    // Source 2 alone, 4-beat frame
    req    = 4'b0100;
    tx_rdy = 1'b1;
    gq.push_back(4'b0100);
    @(negedge clk);
    chk("t1_grant_lat", 134'(ov_grant), 134'(4'b0100));
    req = 4'b0000;
    send(2, 2'b01, 0);
    send(2, 2'b11, 1);
    send(2, 2'b11, 2);
    send(2, 2'b10, 3);
    chk("t1_grant_drop", 134'(ov_grant), 134'(0));
    // rr_ptr must now be 3: with 2 and 3 requesting, 3 wins, no earlier than t+3
    req = 4'b1100;
    gq.push_back(4'b1000);
    @(negedge clk);
    chk("t1_gap", 134'(ov_grant), 134'(0));
    @(negedge clk);
    chk("t1_rr3", 134'(ov_grant), 134'(4'b1000));
    req = 4'b0000;
    send(3, 2'b01, 0);
    send(3, 2'b10, 1);

    // All four requesting, 3-beat frames: order 0,1,2,3,0
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      gq.push_back(4'b0001 << (k % 4));
      wait_grant(k % 4);
      if (k == 4) req = 4'b0000;
      send(k % 4, 2'b01, 10 + k);
      send(k % 4, 2'b11, 20 + k);
      send(k % 4, 2'b10, 30 + k);
      chk("t2_drop", 134'(ov_grant), 134'(0));
      @(negedge clk);
      chk("t2_gap", 134'(ov_grant), 134'(0));
    end
    chk("t2_err", 134'(ov_err_cnt), 134'(0));

    // i_tx_rdy low holds off arbitration
    tx_rdy = 1'b0;
    req    = 4'b0010;
    repeat (3) begin
      @(negedge clk);
      chk("t3_no_grant", 134'(ov_grant), 134'(0));
    end
    tx_rdy = 1'b1;
    gq.push_back(4'b0010);
    @(negedge clk);
    chk("t3_rdy_grant", 134'(ov_grant), 134'(4'b0010));
    req = 4'b0000;

    // Body before head is dropped and counted; following frame intact
    drive(1, 2'b11, pl(1, 99), 1'b0, 2'b11);
    chk("t4_err1", 134'(ov_err_cnt), 134'(1));
    send(1, 2'b01, 40);
    send(1, 2'b11, 41);
    send(1, 2'b10, 42);
    chk("t4_err_hold", 134'(ov_err_cnt), 134'(1));

    // Mid-frame head truncates; a non-granted writer is ignored
    req = 4'b0100;
    gq.push_back(4'b0100);
    wait_grant(2);
    req = 4'b0000;
    send(2, 2'b01, 50);
    data[0] = {2'b11, pl(0, 77)};
    wr[0]   = 1'b1;
    send(2, 2'b11, 51);
    drive(2, 2'b01, pl(2, 52), 1'b1, 2'b10);
    wr[0] = 1'b0;
    chk("t5_err2", 134'(ov_err_cnt), 134'(2));
    chk("t5_drop", 134'(ov_grant), 134'(0));
    req = 4'b0001;
    gq.push_back(4'b0001);
    @(negedge clk);
    chk("t5_gap", 134'(ov_grant), 134'(0));
    @(negedge clk);
    chk("t5_idle_regrant", 134'(ov_grant), 134'(4'b0001));
    req = 4'b0000;
    send(0, 2'b01, 60);
    send(0, 2'b10, 61);

`ifdef LCM_ARB_TIMEOUT_EN
    // Stall after head: abort after 8 idle cycles, next requester 2 cycles later
    req = 4'b1001;
    gq.push_back(4'b1000);
    wait_grant(3);
    req = 4'b0001;
    send(3, 2'b01, 70);
    exp_q.push_back({2'b10, 132'b0});
    repeat (7) @(negedge clk);
    chk("t6_hold", 134'(ov_grant), 134'(4'b1000));
    @(negedge clk);
    chk("t6_abort_drop", 134'(ov_grant), 134'(0));
    chk("t6_tmo_cnt", 134'(ov_timeout_cnt), 134'(1));
    gq.push_back(4'b0001);
    @(negedge clk);
    chk("t6_gap", 134'(ov_grant), 134'(0));
    @(negedge clk);
    chk("t6_next_grant", 134'(ov_grant), 134'(4'b0001));
    req = 4'b0000;
    send(0, 2'b01, 80);
    send(0, 2'b10, 81);
`else
    chk("t6_tmo_tied", 134'(ov_timeout_cnt), 134'(0));
`endif

    repeat (3) @(negedge clk);
    chk("final_err", 134'(ov_err_cnt), 134'(2));
    chk("final_beats_left", 134'(exp_q.size()), 134'(0));
    chk("final_grants_left", 134'(gq.size()), 134'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
